// File: rtl/fnd_pkg.sv
// Shared constants for the FND scan controller: active-low segment codes,
// the blank pattern and the scan FSM state encoding.
package fnd_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_DRIVE = 2'd1;
  localparam logic [1:0] STATE_GUARD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_IDLE,
    ST_DRIVE = STATE_DRIVE,
    ST_GUARD = STATE_GUARD
  } fnd_state_e;

  // Hex nibble to active-low pattern with the dp bit (bit7) off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational nibble + dp + blank to active-low seven-segment pattern.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // A blanked digit still shows its decimal point if requested.
  always_comb begin
    if (blank_i) begin
      seg_o = dp_i ? 8'h7F : SEG_BLANK;
    end else begin
      seg_o = hex_to_seg(nibble_i) & {~dp_i, 7'h7F};
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode FND driver: time-scans NUM_DIGITS digits with a dark
// guard gap, leading-zero blanking and per-frame input latching.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 100000,
  parameter int GUARD_CYCLES = 1000,
  localparam int IDX_W       = $clog2(NUM_DIGITS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_enable,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic [NUM_DIGITS-1:0]   i_dp,
  input  logic                    i_blank_lz,
  output logic [NUM_DIGITS-1:0]   o_position,
  output logic [7:0]              o_segment,
  output logic [IDX_W-1:0]        o_digit_idx,
  output logic                    o_frame_start
);

  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  fnd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        value_q, value_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   position_q, position_d;
  logic [7:0]              segment_q, segment_d;
  logic                    frame_start_q, frame_start_d;

  logic                    latch_s;
  logic [IDX_W-1:0]        next_idx_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [3:0]              nibble_s;
  logic                    dp_sel_s;
  logic                    blank_sel_s;
  logic [7:0]              seg_pat_s;

  // Digit index after the current one, wrapping to the rightmost digit.
  always_comb begin
    if (idx_q == LAST_IDX) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = idx_q + IDX_W'(1);
    end
  end

  // Leading-zero mask of the incoming value; only consumed on a latch edge.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_mask_s = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run     = zero_run & (i_value[4*k +: 4] == 4'h0);
      lz_mask_s[k] = i_blank_lz & zero_run & (k != 0);
    end
  end

  // Scan FSM: state, dwell counter and digit index; flags the frame latch edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    latch_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_enable) begin
          state_d = ST_DRIVE;
          latch_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRIVE: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (GUARD_CYCLES > 0) begin
            state_d = ST_GUARD;
          end else begin
            state_d = ST_DRIVE;
            idx_d   = next_idx_s;
            latch_s = (next_idx_s == '0);
          end
        end else begin
          state_d = ST_DRIVE;
        end
      end
      ST_GUARD: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == GUARD_LAST) begin
          state_d = ST_DRIVE;
          cnt_d   = '0;
          idx_d   = next_idx_s;
          latch_s = (next_idx_s == '0);
        end else begin
          state_d = ST_GUARD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Frame snapshot; held for the whole frame so mid-frame input changes never tear.
  always_comb begin
    if (latch_s) begin
      value_d = i_value;
      dp_d    = i_dp;
      blank_d = lz_mask_s;
    end else begin
      value_d = value_q;
      dp_d    = dp_q;
      blank_d = blank_q;
    end
    frame_start_d = latch_s;
  end

  // Select the digit that will be shown after this edge.
  always_comb begin
    nibble_s    = value_d[{idx_d, 2'b00} +: 4];
    dp_sel_s    = dp_d[idx_d];
    blank_sel_s = blank_d[idx_d];
  end

  fnd_seg_decoder u_seg_decoder (
    .nibble_i (nibble_s),
    .dp_i     (dp_sel_s),
    .blank_i  (blank_sel_s),
    .seg_o    (seg_pat_s)
  );

  // Next output values: only DRIVE lights a digit.
  always_comb begin
    if (state_d == ST_DRIVE) begin
      position_d = ~(NUM_DIGITS'(1) << idx_d);
      segment_d  = seg_pat_s;
    end else begin
      position_d = '1;
      segment_d  = SEG_BLANK;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      value_q       <= '0;
      dp_q          <= '0;
      blank_q       <= '0;
      position_q    <= '1;
      segment_q     <= SEG_BLANK;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      value_q       <= value_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      position_q    <= position_d;
      segment_q     <= segment_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_position    = position_q;
  assign o_segment     = segment_q;
  assign o_digit_idx   = idx_q;
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench: a 4-digit scanner with a 1-cycle guard and a guard-less twin.
module tb_fnd_scan_controller;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz;

  logic [3:0]  pos, pos0;
  logic [7:0]  seg, seg0;
  logic [1:0]  idx, idx0;
  logic        fs, fs0;

  int checks = 0;
  int errors = 0;

  fnd_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(1)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_enable      (en),
    .i_value       (value),
    .i_dp          (dp),
    .i_blank_lz    (lz),
    .o_position    (pos),
    .o_segment     (seg),
    .o_digit_idx   (idx),
    .o_frame_start (fs)
  );

  fnd_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(4), .GUARD_CYCLES(0)) dut0 (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_enable      (en),
    .i_value       (value),
    .i_dp          (dp),
    .i_blank_lz    (lz),
    .o_position    (pos0),
    .o_segment     (seg0),
    .o_digit_idx   (idx0),
    .o_frame_start (fs0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][7:0] segs;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s digit %0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  // Four DRIVE samples for digit k followed by its single guard sample.
  task automatic check_digit(input int k, input logic [7:0] exp_seg);
    logic [3:0] exp_pos;
    exp_pos = ~(4'b0001 << k);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      chk("pos", k, pos, exp_pos);
      chk("seg", k, seg, exp_seg);
      chk("idx", k, idx, k);
      chk("frame_start", k, fs, (c == 0 && k == 0));
    end
    step();
    chk("guard_pos", k, pos, 4'hF);
    chk("guard_seg", k, seg, 8'hFF);
    chk("guard_idx", k, idx, k);
    chk("guard_fs", k, fs, 1'b0);
  endtask

  task automatic check_frame(input logic [3:0][7:0] segs);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      check_digit(k, segs[k]);
    end
  endtask

  initial begin
    logic [3:0][7:0] segs_1234;
    logic [3:0]      exp_pos;
    segs_1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};

    vecs[0] = '{16'hABCD, 4'b0000, 1'b0, {8'h88, 8'h83, 8'hC6, 8'hA1}};
    vecs[1] = '{16'h0050, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'h92, 8'hC0}};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    vecs[3] = '{16'h0123, 4'b0100, 1'b1, {8'hFF, 8'h79, 8'hA4, 8'hB0}};
    vecs[4] = '{16'h0050, 4'b1010, 1'b0, {8'h40, 8'hC0, 8'h12, 8'hC0}};
    vecs[5] = '{16'h0000, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'hFF, 8'hC0}};
    vecs[6] = '{16'h00F0, 4'b0001, 1'b1, {8'hFF, 8'hFF, 8'h8E, 8'h40}};
    vecs[7] = '{16'h6789, 4'b0000, 1'b1, {8'h82, 8'hF8, 8'h80, 8'h90}};
    vecs[8] = '{16'h0E00, 4'b0000, 1'b1, {8'hFF, 8'h86, 8'hC0, 8'hC0}};
    vecs[9] = '{16'h1234, 4'b0000, 1'b1, {8'hF9, 8'hA4, 8'hB0, 8'h99}};

    rst_n = 1'b0;
    en    = 1'b0;
    value = 16'h1234;
    dp    = 4'b0000;
    lz    = 1'b0;
    step();
    step();
    chk("rst_pos", 0, pos, 4'hF);
    chk("rst_seg", 0, seg, 8'hFF);
    chk("rst_idx", 0, idx, 2'd0);
    chk("rst_fs", 0, fs, 1'b0);
    chk("rst_pos0", 0, pos0, 4'hF);
    chk("rst_seg0", 0, seg0, 8'hFF);

    // First frame of 1234; value changes while digit 1 is driven.
    rst_n = 1'b1;
    en    = 1'b1;
    step();
    check_digit(0, 8'h99);
    step();
    value = 16'hABCD;
    check_digit(1, 8'hB0);
    step();
    check_digit(2, 8'hA4);
    step();
    check_digit(3, 8'hF9);

    for (int i = 0; i < 10; i++) begin
      value = vecs[i].value;
      dp    = vecs[i].dp;
      lz    = vecs[i].lz;
      step();
      check_frame(vecs[i].segs);
    end

    // Disable during the third DRIVE cycle of digit 2.
    value = 16'h4321;
    dp    = 4'b0000;
    lz    = 1'b0;
    step();
    check_digit(0, 8'hF9);
    step();
    check_digit(1, 8'hA4);
    step();
    chk("dis_pos_d2", 2, pos, 4'b1011);
    step();
    step();
    chk("dis_seg_d2", 2, seg, 8'hB0);
    en = 1'b0;
    step();
    chk("dis_pos", 2, pos, 4'hF);
    chk("dis_seg", 2, seg, 8'hFF);
    chk("dis_idx", 2, idx, 2'd0);
    chk("dis_fs", 2, fs, 1'b0);
    step();
    chk("idle_pos", 0, pos, 4'hF);
    chk("idle_seg0", 0, seg0, 8'hFF);
    en    = 1'b1;
    value = 16'h1234;
    step();
    check_digit(0, 8'h99);
    step();
    check_digit(1, 8'hB0);

    // Async reset in the guard after digit 1; the guard-less twin is mid-DRIVE.
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_pos", 1, pos, 4'hF);
    chk("areset_seg", 1, seg, 8'hFF);
    chk("areset_idx", 1, idx, 2'd0);
    chk("areset_pos0", 1, pos0, 4'hF);
    chk("areset_seg0", 1, seg0, 8'hFF);
    chk("areset_idx0", 1, idx0, 2'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    check_frame(segs_1234);

    // Guard-less twin: digits back-to-back, two full frames.
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    step();
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 4; k++) begin
        exp_pos = ~(4'b0001 << k);
        for (int c = 0; c < 4; c++) begin
          if (f > 0 || k > 0 || c > 0) step();
          chk("ng_pos", k, pos0, exp_pos);
          chk("ng_seg", k, seg0, segs_1234[k]);
          chk("ng_idx", k, idx0, k);
          chk("ng_fs", k, fs0, (c == 0 && k == 0));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
